// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one enable-pulsed load/store port
// between the IFU (read-only) and the LSU, one transaction at a time.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1,
    parameter bit PRIO_RR = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_raddr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        mem_ld_wen,
    output logic        mem_st_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_LD = CW'(MEM_LAT);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [1:0]    state;
    logic          owner_lsu;
    logic          last_lsu;
    logic          wen_q;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic [31:0]   raddr_q;
    logic [31:0]   waddr_q;
    logic [31:0]   wdata_q;
    logic [7:0]    wmask_q;

    logic idle;
    logic pick_lsu;
    logic accept;
    logic owner_ready;

    assign idle = (state == S_IDLE);

    // Choose the requester that wins this cycle; ties alternate or favour LSU
    always_comb begin
        pick_lsu = lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) begin
            pick_lsu = PRIO_RR ? !last_lsu : 1'b1;
        end
    end

    assign lsu_req_ready = idle & pick_lsu;
    assign ifu_req_ready = idle & ifu_req_valid & ~pick_lsu;
    assign accept        = ifu_req_ready | lsu_req_ready;
    assign owner_ready   = owner_lsu ? lsu_resp_ready : ifu_resp_ready;

    assign mem_ld_wen     = (state == S_ISSUE) & ~wen_q;
    assign mem_st_wen     = (state == S_ISSUE) & wen_q;
    assign ifu_resp_valid = (state == S_RESP) & ~owner_lsu;
    assign lsu_resp_valid = (state == S_RESP) & owner_lsu;
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;
    assign mem_raddr      = raddr_q;
    assign mem_waddr      = waddr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    // Transaction sequencing, latency countdown and response capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt   <= LAT_LD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - ONE;
                    if (cnt == ONE) begin
                        rdata_q <= wen_q ? 32'h0 : mem_rdata;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (owner_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Latch the accepted request; port fields hold until the next one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b0;
            wen_q     <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else if (lsu_req_ready) begin
            owner_lsu <= 1'b1;
            last_lsu  <= 1'b1;
            wen_q     <= lsu_wen;
            if (lsu_wen) begin
                waddr_q <= lsu_addr;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
            end else begin
                raddr_q <= lsu_addr;
            end
        end else if (ifu_req_ready) begin
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b0;
            wen_q     <= 1'b0;
            raddr_q   <= ifu_raddr;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is MEM_LAT=1 round-robin,
// instance 1 is MEM_LAT=3 fixed priority; a memory emulator feeds both.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid [2];
    logic        ifu_req_ready [2];
    logic [31:0] ifu_raddr     [2];
    logic        ifu_resp_valid[2];
    logic        ifu_resp_ready[2];
    logic [31:0] ifu_rdata     [2];
    logic        lsu_req_valid [2];
    logic        lsu_req_ready [2];
    logic        lsu_wen       [2];
    logic [31:0] lsu_addr      [2];
    logic [31:0] lsu_wdata     [2];
    logic [7:0]  lsu_wmask     [2];
    logic        lsu_resp_valid[2];
    logic        lsu_resp_ready[2];
    logic [31:0] lsu_rdata     [2];
    logic        mem_ld_wen    [2];
    logic        mem_st_wen    [2];
    logic [31:0] mem_raddr     [2];
    logic [31:0] mem_waddr     [2];
    logic [31:0] mem_wdata     [2];
    logic [7:0]  mem_wmask     [2];
    logic [31:0] mem_rdata     [2];

    int          pd_cnt [2];
    logic [31:0] pd_addr[2];
    bit          last_m [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .MEM_LAT ((g == 0) ? 1 : 3),
            .PRIO_RR (g == 0)
        ) u_dut (
            .clock          (clock),
            .reset          (reset),
            .ifu_req_valid  (ifu_req_valid[g]),
            .ifu_req_ready  (ifu_req_ready[g]),
            .ifu_raddr      (ifu_raddr[g]),
            .ifu_resp_valid (ifu_resp_valid[g]),
            .ifu_resp_ready (ifu_resp_ready[g]),
            .ifu_rdata      (ifu_rdata[g]),
            .lsu_req_valid  (lsu_req_valid[g]),
            .lsu_req_ready  (lsu_req_ready[g]),
            .lsu_wen        (lsu_wen[g]),
            .lsu_addr       (lsu_addr[g]),
            .lsu_wdata      (lsu_wdata[g]),
            .lsu_wmask      (lsu_wmask[g]),
            .lsu_resp_valid (lsu_resp_valid[g]),
            .lsu_resp_ready (lsu_resp_ready[g]),
            .lsu_rdata      (lsu_rdata[g]),
            .mem_ld_wen     (mem_ld_wen[g]),
            .mem_st_wen     (mem_st_wen[g]),
            .mem_raddr      (mem_raddr[g]),
            .mem_waddr      (mem_waddr[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_wmask      (mem_wmask[g]),
            .mem_rdata      (mem_rdata[g])
        );
    end

    always #5 clock = ~clock;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F11;
    endfunction

    // Memory emulator: data is valid only in the cycle MEM_LAT edges after the enable
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_ld_wen[k]) begin
                pd_cnt[k]  <= lat_of(k);
                pd_addr[k] <= mem_raddr[k];
            end else if (pd_cnt[k] != 0) begin
                pd_cnt[k] <= pd_cnt[k] - 1;
            end
        end
    end

    // Outside the valid window the port returns junk
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = 32'hBAD0_0000 ^ pd_addr[k];
            if (pd_cnt[k] == 1) mem_rdata[k] = rd_val(pd_addr[k]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req_ifu(input int k, input logic [31:0] a);
        ifu_req_valid[k] = 1'b1;
        ifu_raddr[k]     = a;
    endtask

    task automatic req_lsu(input int k, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [7:0] m);
        lsu_req_valid[k] = 1'b1;
        lsu_wen[k]       = w;
        lsu_addr[k]      = a;
        lsu_wdata[k]     = d;
        lsu_wmask[k]     = m;
    endtask

    // One full transaction with whatever requests are pending; entered on a negedge
    task automatic serve(input int k, input int hold, input int exp_g);
        bit          lw;
        bit          rd;
        bit          got;
        logic [31:0] a;
        logic [31:0] d;
        logic [7:0]  m;
        logic [31:0] er;
        int          lat;
        int          cyc;
        int          nld;
        int          nst;
        lat = lat_of(k);
        if (ifu_req_valid[k] && lsu_req_valid[k])
            lw = (k == 0) ? !last_m[k] : 1'b1;
        else
            lw = lsu_req_valid[k];
        if (lw) begin
            rd = !lsu_wen[k];
            a  = lsu_addr[k];
            d  = lsu_wdata[k];
            m  = lsu_wmask[k];
        end else begin
            rd = 1'b1;
            a  = ifu_raddr[k];
            d  = '0;
            m  = '0;
        end
        er = rd ? rd_val(a) : 32'h0;
        ifu_resp_ready[k] = lw;
        lsu_resp_ready[k] = !lw;
        #1;
        if (exp_g >= 0) chk("grant_dir", lsu_req_ready[k], 32'(exp_g));
        chk("ifu_req_ready", ifu_req_ready[k], !lw);
        chk("lsu_req_ready", lsu_req_ready[k], lw);
        @(posedge clock);
        last_m[k] = lw;
        @(negedge clock);
        if (lw) lsu_req_valid[k] = 1'b0;
        else ifu_req_valid[k] = 1'b0;
        nld = 0;
        nst = 0;
        got = 1'b0;
        cyc = 1;
        while (!got && cyc <= lat + 6) begin
            if (mem_ld_wen[k]) begin
                nld++;
                chk("mem_raddr", mem_raddr[k], a);
            end
            if (mem_st_wen[k]) begin
                nst++;
                chk("mem_waddr", mem_waddr[k], a);
                chk("mem_wdata", mem_wdata[k], d);
                chk("mem_wmask", {24'h0, mem_wmask[k]}, {24'h0, m});
            end
            chk("busy_ready", {30'h0, ifu_req_ready[k], lsu_req_ready[k]}, 0);
            got = lw ? lsu_resp_valid[k] : ifu_resp_valid[k];
            if (!got) begin
                @(negedge clock);
                cyc++;
            end
        end
        chk("latency", cyc, lat + 2);
        chk("ld_pulses", nld, {31'h0, rd});
        chk("st_pulses", nst, {31'h0, !rd});
        chk("other_resp", lw ? ifu_resp_valid[k] : lsu_resp_valid[k], 0);
        chk("rdata", lw ? lsu_rdata[k] : ifu_rdata[k], er);
        repeat (hold) begin
            @(negedge clock);
            chk("hold_valid", lw ? lsu_resp_valid[k] : ifu_resp_valid[k], 1);
            chk("hold_rdata", lw ? lsu_rdata[k] : ifu_rdata[k], er);
            chk("hold_misc", {28'h0, ifu_req_ready[k], lsu_req_ready[k],
                              mem_ld_wen[k], mem_st_wen[k]}, 0);
        end
        if (lw) lsu_resp_ready[k] = 1'b1;
        else ifu_resp_ready[k] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ifu_resp_ready[k] = 1'b0;
        lsu_resp_ready[k] = 1'b0;
        chk("resp_drop", {30'h0, ifu_resp_valid[k], lsu_resp_valid[k]}, 0);
    endtask

    task automatic chk_idle_outputs(input string tag, input int k);
        chk(tag, {26'h0, ifu_req_ready[k], lsu_req_ready[k], ifu_resp_valid[k],
                  lsu_resp_valid[k], mem_ld_wen[k], mem_st_wen[k]}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int g3[3];
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ifu_req_valid[k]  = 1'b0;
            ifu_raddr[k]      = '0;
            ifu_resp_ready[k] = 1'b0;
            lsu_req_valid[k]  = 1'b0;
            lsu_wen[k]        = 1'b0;
            lsu_addr[k]       = '0;
            lsu_wdata[k]      = '0;
            lsu_wmask[k]      = '0;
            lsu_resp_ready[k] = 1'b0;
            last_m[k]         = 1'b0;
        end
        repeat (2) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk_idle_outputs("reset_ctl", k);
            chk("reset_ifu_rdata", ifu_rdata[k], 0);
            chk("reset_lsu_rdata", lsu_rdata[k], 0);
            chk("reset_raddr", mem_raddr[k], 0);
            chk("reset_waddr", mem_waddr[k], 0);
            chk("reset_wdata", mem_wdata[k], 0);
            chk("reset_wmask", {24'h0, mem_wmask[k]}, 0);
        end
        reset = 1'b0;
        @(negedge clock);

        req_ifu(0, 32'h8000_0000);
        serve(0, 0, 0);
        req_lsu(0, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F);
        serve(0, 0, 1);
        req_lsu(0, 1'b0, 32'h8000_0200, 32'h0, 8'h0);
        serve(0, 5, 1);

        req_lsu(0, 1'b0, 32'h8000_2000, 32'h0, 8'h0);
        #1 chk("rst_wait_accept", lsu_req_ready[0], 1);
        @(posedge clock);
        @(negedge clock);
        lsu_req_valid[0] = 1'b0;
        chk("rst_wait_issue", mem_ld_wen[0], 1);
        @(negedge clock);
        reset = 1'b1;
        last_m[0] = 1'b0;
        last_m[1] = 1'b0;
        #1 chk_idle_outputs("rst_in_wait", 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            chk_idle_outputs("post_reset_quiet", 0);
        end

        g3 = '{1, 0, 1};
        for (int i = 0; i < 3; i++) begin
            if (!ifu_req_valid[0]) req_ifu(0, 32'h8000_0100 + 32'(i));
            if (!lsu_req_valid[0]) req_lsu(0, 1'b0, 32'h8000_3000 + 32'(i), 0, 0);
            serve(0, 0, g3[i]);
        end
        serve(0, 0, 0);

        req_ifu(1, 32'h8000_0040);
        serve(1, 0, 0);

        req_ifu(1, 32'h8000_0080);
        @(posedge clock);
        @(negedge clock);
        ifu_req_valid[1] = 1'b0;
        chk("rst_issue_en", mem_ld_wen[1], 1);
        reset = 1'b1;
        #1 chk_idle_outputs("rst_in_issue", 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            chk_idle_outputs("post_reset_quiet1", 1);
        end

        g3 = '{1, 1, 1};
        for (int i = 0; i < 3; i++) begin
            if (!ifu_req_valid[1]) req_ifu(1, 32'h8000_0500 + 32'(i));
            if (!lsu_req_valid[1]) req_lsu(1, 1'(i), 32'h8000_4000 + 32'(i),
                                           32'h1234_0000 + 32'(i), 8'hA5);
            serve(1, 0, g3[i]);
        end
        serve(1, 0, 0);

        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 40; r++) begin
                if (!ifu_req_valid[k] && ($urandom % 2) == 1)
                    req_ifu(k, $urandom);
                if (!lsu_req_valid[k] && ($urandom % 2) == 1)
                    req_lsu(k, 1'($urandom % 2), $urandom, $urandom, 8'($urandom));
                if (!ifu_req_valid[k] && !lsu_req_valid[k])
                    req_ifu(k, $urandom);
                serve(k, $urandom_range(0, 3), -1);
            end
            while (ifu_req_valid[k] || lsu_req_valid[k]) serve(k, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
